// File: rtl/dca_matrix_register_stream_pkg.sv
// Shared encodings and types for the streaming DCA matrix register:
// controller state codes, per-cycle operation selects and a counter-width helper.
package dca_matrix_register_stream_pkg;

  localparam int BW_STATE = 2;

  localparam logic [BW_STATE-1:0] ST_IDLE  = 2'd0;
  localparam logic [BW_STATE-1:0] ST_LOAD  = 2'd1;
  localparam logic [BW_STATE-1:0] ST_DRAIN = 2'd2;

  // At most one field is set in any cycle; the controller resolves priority.
  typedef struct packed {
    logic init;
    logic bulk;
    logic load;
    logic drain;
    logic transpose;
    logic shift_up;
    logic shift_left;
  } op_sel_t;

  function automatic int rowcnt_width(input int num_row);
    return $clog2(num_row + 1);
  endfunction

endpackage

// File: rtl/dca_matrix_register_stream_if.sv
// Bus bundle for the streaming matrix register: bulk access, row load/drain
// handshakes and matrix read-out. The master drives commands, the slave is the register.
interface dca_matrix_register_stream_if #(
  parameter int NUM_ROW          = 8,
  parameter int NUM_COL          = 8,
  parameter int BW_TENSOR_SCALAR = 32
);

  localparam int BW_ROW    = NUM_COL * BW_TENSOR_SCALAR;
  localparam int BW_MATRIX = NUM_ROW * BW_ROW;

  logic                 init;
  logic                 all_wenable;
  logic [BW_MATRIX-1:0] all_wdata_list2d;
  logic                 shift_up;
  logic                 shift_left;
  logic                 transpose;
  logic                 row_wvalid;
  logic                 row_wready;
  logic [BW_ROW-1:0]    row_wdata_list;
  logic                 load_done;
  logic                 drain_start;
  logic                 row_rvalid;
  logic                 row_rready;
  logic [BW_ROW-1:0]    row_rdata_list;
  logic                 busy;
  logic [BW_MATRIX-1:0] all_rdata_list2d;
  logic [BW_ROW-1:0]    upmost_rdata_list1d;

  modport master (
    output init, all_wenable, all_wdata_list2d, shift_up, shift_left, transpose,
    output row_wvalid, row_wdata_list, drain_start, row_rready,
    input  row_wready, load_done, row_rvalid, row_rdata_list, busy,
    input  all_rdata_list2d, upmost_rdata_list1d
  );

  modport slave (
    input  init, all_wenable, all_wdata_list2d, shift_up, shift_left, transpose,
    input  row_wvalid, row_wdata_list, drain_start, row_rready,
    output row_wready, load_done, row_rvalid, row_rdata_list, busy,
    output all_rdata_list2d, upmost_rdata_list1d
  );

endinterface

// File: rtl/dca_matrix_register_stream_ctrl.sv
// Load/drain controller: owns the stream FSM, row counters and handshake flags,
// and resolves the per-cycle action priority into one-hot operation selects.
module dca_matrix_register_stream_ctrl
  import dca_matrix_register_stream_pkg::*;
#(
  parameter int NUM_ROW      = 8,
  parameter int BW_ROWCNT    = 4,
  parameter bit TRANSPOSE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 init_i,
  input  logic                 all_wenable_i,
  input  logic                 shift_up_i,
  input  logic                 shift_left_i,
  input  logic                 transpose_i,
  input  logic                 row_wvalid_i,
  input  logic                 drain_start_i,
  input  logic                 row_rready_i,
  output logic                 row_wready_o,
  output logic                 row_rvalid_o,
  output logic                 load_done_o,
  output logic                 busy_o,
  output logic [BW_ROWCNT-1:0] wcnt_o,
  output op_sel_t              op_o
);

  localparam logic [BW_ROWCNT-1:0] LAST_ROW = BW_ROWCNT'(NUM_ROW - 1);
  localparam logic [BW_ROWCNT-1:0] CNT_ONE  = BW_ROWCNT'(1);

  logic [BW_STATE-1:0]  state_q, state_d;
  logic [BW_ROWCNT-1:0] wcnt_q, wcnt_d;
  logic [BW_ROWCNT-1:0] rcnt_q, rcnt_d;
  logic                 load_done_q, load_done_d;
  logic                 wready_q, wready_d;
  logic                 rvalid_q, rvalid_d;
  logic                 busy_q, busy_d;

  logic idle_s;
  logic wready_s;
  logic load_acc_s;
  logic drain_acc_s;
  logic drain_go_s;
  logic free_s;

  // A bulk write in IDLE outranks a load beat, so ready drops for that cycle.
  assign idle_s      = (state_q == ST_IDLE);
  assign wready_s    = wready_q && !init_i && !(all_wenable_i && idle_s);
  assign load_acc_s  = row_wvalid_i && wready_s;
  assign drain_acc_s = rvalid_q && row_rready_i && !init_i;
  assign drain_go_s  = idle_s && drain_start_i && !init_i && !all_wenable_i && !load_acc_s;
  assign free_s      = idle_s && !init_i && !all_wenable_i && !load_acc_s && !drain_go_s;

  // Operation selects, highest asserted action only
  always_comb begin
    op_o            = '0;
    op_o.init       = init_i;
    op_o.bulk       = !init_i && all_wenable_i && idle_s;
    op_o.load       = load_acc_s;
    op_o.drain      = drain_acc_s;
    op_o.transpose  = free_s && transpose_i && TRANSPOSE_EN;
    op_o.shift_up   = free_s && !transpose_i && shift_up_i;
    op_o.shift_left = free_s && !transpose_i && !shift_up_i && shift_left_i;
  end

  // Next state, row counters and load-complete pulse
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    load_done_d = 1'b0;
    if (init_i) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
      rcnt_d  = '0;
    end else if (load_acc_s) begin
      if (wcnt_q == LAST_ROW) begin
        state_d     = ST_IDLE;
        wcnt_d      = '0;
        load_done_d = 1'b1;
      end else begin
        state_d = ST_LOAD;
        wcnt_d  = wcnt_q + CNT_ONE;
      end
    end else if (drain_acc_s) begin
      if (rcnt_q == LAST_ROW) begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end else begin
        rcnt_d = rcnt_q + CNT_ONE;
      end
    end else if (drain_go_s) begin
      state_d = ST_DRAIN;
    end else begin
      state_d = state_q;
    end
  end

  // Handshake flags decoded from the upcoming state so they leave a register
  always_comb begin
    wready_d = 1'b1;
    rvalid_d = 1'b0;
    busy_d   = 1'b0;
    case (state_d)
      ST_IDLE: begin
        wready_d = 1'b1;
        rvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
      ST_LOAD: begin
        wready_d = 1'b1;
        rvalid_d = 1'b0;
        busy_d   = 1'b1;
      end
      ST_DRAIN: begin
        wready_d = 1'b0;
        rvalid_d = 1'b1;
        busy_d   = 1'b1;
      end
      default: begin
        wready_d = 1'b0;
        rvalid_d = 1'b0;
        busy_d   = 1'b1;
      end
    endcase
  end

  // Controller state registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      load_done_q <= 1'b0;
      wready_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      load_done_q <= load_done_d;
      wready_q    <= wready_d;
      rvalid_q    <= rvalid_d;
      busy_q      <= busy_d;
    end
  end

  assign row_wready_o = wready_s;
  assign row_rvalid_o = rvalid_q;
  assign load_done_o  = load_done_q;
  assign busy_o       = busy_q;
  assign wcnt_o       = wcnt_q;

endmodule

// File: rtl/dca_matrix_register_stream.sv
// NUM_ROW x NUM_COL scalar matrix register with bulk, shift, transpose and
// row-streaming load/drain access; the controller picks one operation per cycle.
module dca_matrix_register_stream
  import dca_matrix_register_stream_pkg::*;
#(
  parameter int                          NUM_ROW          = 8,
  parameter int                          NUM_COL          = 8,
  parameter int                          BW_TENSOR_SCALAR = 32,
  parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE      = '0,
  parameter logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE       = RESET_VALUE
) (
  input logic                         clk,
  input logic                         rstnn,
  dca_matrix_register_stream_if.slave bus
);

  localparam int BW_ROW       = NUM_COL * BW_TENSOR_SCALAR;
  localparam int BW_MATRIX    = NUM_ROW * BW_ROW;
  localparam int BW_ROWCNT    = rowcnt_width(NUM_ROW);
  localparam bit TRANSPOSE_EN = (NUM_ROW == NUM_COL);

  logic [BW_TENSOR_SCALAR-1:0] mat_q   [NUM_ROW][NUM_COL];
  logic [BW_TENSOR_SCALAR-1:0] mat_d   [NUM_ROW][NUM_COL];
  logic [BW_TENSOR_SCALAR-1:0] trans_s [NUM_ROW][NUM_COL];
  logic [BW_MATRIX-1:0]        all_rdata_s;
  logic [BW_ROW-1:0]           row0_s;
  logic [BW_ROWCNT-1:0]        wcnt_s;
  op_sel_t                     op_s;

  dca_matrix_register_stream_ctrl #(
    .NUM_ROW      (NUM_ROW),
    .BW_ROWCNT    (BW_ROWCNT),
    .TRANSPOSE_EN (TRANSPOSE_EN)
  ) u_ctrl (
    .clk           (clk),
    .rstnn         (rstnn),
    .init_i        (bus.init),
    .all_wenable_i (bus.all_wenable),
    .shift_up_i    (bus.shift_up),
    .shift_left_i  (bus.shift_left),
    .transpose_i   (bus.transpose),
    .row_wvalid_i  (bus.row_wvalid),
    .drain_start_i (bus.drain_start),
    .row_rready_i  (bus.row_rready),
    .row_wready_o  (bus.row_wready),
    .row_rvalid_o  (bus.row_rvalid),
    .load_done_o   (bus.load_done),
    .busy_o        (bus.busy),
    .wcnt_o        (wcnt_s),
    .op_o          (op_s)
  );

  // A non-square matrix has no transpose, so that path collapses to identity.
  if (TRANSPOSE_EN) begin : g_transpose
    // Transposed view of the current contents
    always_comb begin
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          trans_s[r][c] = mat_q[c][r];
        end
      end
    end
  end else begin : g_no_transpose
    // Identity view when transpose is unavailable
    always_comb begin
      trans_s = mat_q;
    end
  end

  // Element next-state mux driven by the one-hot operation select
  always_comb begin
    mat_d = mat_q;
    if (op_s.init) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          mat_d[r][c] = INIT_VALUE;
        end
      end
    end else if (op_s.bulk) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          mat_d[r][c] = bus.all_wdata_list2d[r*BW_ROW + c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR];
        end
      end
    end else if (op_s.load) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          mat_d[r][c] = (wcnt_s == BW_ROWCNT'(r)) ?
                        bus.row_wdata_list[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] : mat_q[r][c];
        end
      end
    end else if (op_s.drain || op_s.shift_up) begin
      for (int r = 0; r < NUM_ROW - 1; r++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          mat_d[r][c] = mat_q[r+1][c];
        end
      end
      for (int c = 0; c < NUM_COL; c++) begin
        mat_d[NUM_ROW-1][c] = INIT_VALUE;
      end
    end else if (op_s.transpose) begin
      mat_d = trans_s;
    end else if (op_s.shift_left) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int c = 0; c < NUM_COL - 1; c++) begin
          mat_d[r][c] = mat_q[r][c+1];
        end
        mat_d[r][NUM_COL-1] = INIT_VALUE;
      end
    end else begin
      mat_d = mat_q;
    end
  end

  // Element storage
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          mat_q[r][c] <= RESET_VALUE;
        end
      end
    end else begin
      mat_q <= mat_d;
    end
  end

  // Flatten storage: row 0 and column 0 land in the LSBs
  always_comb begin
    all_rdata_s = '0;
    for (int r = 0; r < NUM_ROW; r++) begin
      for (int c = 0; c < NUM_COL; c++) begin
        all_rdata_s[r*BW_ROW + c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = mat_q[r][c];
      end
    end
  end

  assign row0_s                  = all_rdata_s[BW_ROW-1:0];
  assign bus.all_rdata_list2d    = all_rdata_s;
  assign bus.upmost_rdata_list1d = row0_s;
  assign bus.row_rdata_list      = row0_s;

endmodule

// File: tb/tb_dca_matrix_register_stream.sv
// Randomised self-checking bench: a 4x3 instance against a row/column array model,
// plus a 3x3 instance exercising transpose.
module tb_dca_matrix_register_stream;

  logic clk = 1'b0;
  logic rstnn;
  always #5 clk = ~clk;

  dca_matrix_register_stream_if #(.NUM_ROW(4), .NUM_COL(3), .BW_TENSOR_SCALAR(8)) ifa ();
  dca_matrix_register_stream_if #(.NUM_ROW(3), .NUM_COL(3), .BW_TENSOR_SCALAR(8)) ifb ();

  dca_matrix_register_stream #(
    .NUM_ROW(4), .NUM_COL(3), .BW_TENSOR_SCALAR(8), .RESET_VALUE(8'h00), .INIT_VALUE(8'hFF)
  ) dut_a (.clk(clk), .rstnn(rstnn), .bus(ifa));

  dca_matrix_register_stream #(
    .NUM_ROW(3), .NUM_COL(3), .BW_TENSOR_SCALAR(8), .RESET_VALUE(8'h00), .INIT_VALUE(8'hFF)
  ) dut_b (.clk(clk), .rstnn(rstnn), .bus(ifb));

  int n_checks = 0;
  int n_errors = 0;
  int m [4][3];
  int lw = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] model_flat();
    logic [95:0] f;
    f = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        f[(r*3+c)*8 +: 8] = 8'(m[r][c]);
    return f;
  endfunction

  task automatic model_fill(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = v;
  endtask

  task automatic model_set_flat(input logic [95:0] f);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = int'(f[(r*3+c)*8 +: 8]);
  endtask

  task automatic model_shift_up();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (r < 3) m[r][c] = m[r+1][c];
        else m[r][c] = 255;
  endtask

  task automatic model_shift_left();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (c < 2) m[r][c] = m[r][c+1];
        else m[r][c] = 255;
  endtask

  task automatic load_beat(input logic [23:0] row);
    ifa.row_wvalid     = 1'b1;
    ifa.row_wdata_list = row;
    #1;
    check_eq("wready_beat", 96'(ifa.row_wready), 96'(1'b1));
    tick();
    ifa.row_wvalid = 1'b0;
    for (int c = 0; c < 3; c++) m[lw][c] = int'(row[c*8 +: 8]);
    lw = (lw + 1) % 4;
    check_eq("load_done", 96'(ifa.load_done), 96'(lw == 0));
    check_eq("busy_load", 96'(ifa.busy), 96'(lw != 0));
  endtask

  function automatic logic [23:0] rnd_row();
    return 24'($urandom);
  endfunction

  initial begin
    logic [95:0] bulk;
    logic [71:0] b_flat;
    logic [71:0] b_exp;
    logic [4:0]  pat;
    int          beats;
    int          op;

    rstnn = 1'b0;
    ifa.init = 1'b0; ifa.all_wenable = 1'b0; ifa.all_wdata_list2d = '0;
    ifa.shift_up = 1'b0; ifa.shift_left = 1'b0; ifa.transpose = 1'b0;
    ifa.row_wvalid = 1'b0; ifa.row_wdata_list = '0; ifa.drain_start = 1'b0; ifa.row_rready = 1'b0;
    ifb.init = 1'b0; ifb.all_wenable = 1'b0; ifb.all_wdata_list2d = '0;
    ifb.shift_up = 1'b0; ifb.shift_left = 1'b0; ifb.transpose = 1'b0;
    ifb.row_wvalid = 1'b0; ifb.row_wdata_list = '0; ifb.drain_start = 1'b0; ifb.row_rready = 1'b0;
    model_fill(0);

    // reset state
    tick();
    check_eq("rst_matrix", ifa.all_rdata_list2d, 96'h0);
    check_eq("rst_busy", 96'(ifa.busy), 96'(1'b0));
    check_eq("rst_rvalid", 96'(ifa.row_rvalid), 96'(1'b0));
    check_eq("rst_load_done", 96'(ifa.load_done), 96'(1'b0));
    @(negedge clk);
    rstnn = 1'b1;
    tick();
    check_eq("wready_after_rst", 96'(ifa.row_wready), 96'(1'b1));

    // streaming load with a gap after the second beat
    load_beat(24'h030201);
    load_beat(24'h060504);
    tick();
    check_eq("gap_load_done", 96'(ifa.load_done), 96'(1'b0));
    check_eq("gap_busy", 96'(ifa.busy), 96'(1'b1));
    load_beat(24'h090807);
    load_beat(24'h0C0B0A);
    check_eq("upmost_after_load", 96'(ifa.upmost_rdata_list1d), 96'(24'h030201));
    check_eq("matrix_after_load", ifa.all_rdata_list2d, model_flat());
    tick();
    check_eq("load_done_one_cycle", 96'(ifa.load_done), 96'(1'b0));

    // drain with backpressure pattern 1,0,1,1,1 (bit 0 first)
    ifa.drain_start = 1'b1;
    tick();
    ifa.drain_start = 1'b0;
    check_eq("drain_rvalid", 96'(ifa.row_rvalid), 96'(1'b1));
    check_eq("drain_busy", 96'(ifa.busy), 96'(1'b1));
    check_eq("drain_wready", 96'(ifa.row_wready), 96'(1'b0));
    pat = 5'b11101;
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      ifa.row_rready = pat[i];
      #1;
      check_eq("drain_rvalid_beat", 96'(ifa.row_rvalid), 96'(beats < 4));
      if (beats < 4) check_eq("drain_rdata", 96'(ifa.row_rdata_list), model_flat() & 96'hFFFFFF);
      tick();
      if (pat[i] && beats < 4) begin
        model_shift_up();
        beats++;
      end
    end
    ifa.row_rready = 1'b0;
    check_eq("drain_busy_end", 96'(ifa.busy), 96'(1'b0));
    check_eq("drain_matrix_ff", ifa.all_rdata_list2d, {12{8'hFF}});

    // abort a partial load with init, then reload from row 0
    load_beat(rnd_row());
    load_beat(rnd_row());
    ifa.init = 1'b1;
    tick();
    ifa.init = 1'b0;
    model_fill(255);
    lw = 0;
    check_eq("abort_matrix", ifa.all_rdata_list2d, model_flat());
    check_eq("abort_busy", 96'(ifa.busy), 96'(1'b0));
    check_eq("abort_load_done", 96'(ifa.load_done), 96'(1'b0));
    for (int i = 0; i < 4; i++) load_beat(rnd_row());
    check_eq("reload_matrix", ifa.all_rdata_list2d, model_flat());

    // bulk write beats a simultaneous load beat
    bulk = {$urandom, $urandom, $urandom};
    ifa.all_wenable = 1'b1;
    ifa.all_wdata_list2d = bulk;
    ifa.row_wvalid = 1'b1;
    ifa.row_wdata_list = rnd_row();
    #1;
    check_eq("bulk_wready_low", 96'(ifa.row_wready), 96'(1'b0));
    tick();
    ifa.all_wenable = 1'b0;
    ifa.row_wvalid = 1'b0;
    model_set_flat(bulk);
    check_eq("bulk_matrix", ifa.all_rdata_list2d, model_flat());
    check_eq("bulk_busy", 96'(ifa.busy), 96'(1'b0));

    // operations requested mid-load are ignored
    load_beat(rnd_row());
    ifa.shift_up = 1'b1;
    ifa.all_wenable = 1'b1;
    ifa.all_wdata_list2d = {$urandom, $urandom, $urandom};
    tick();
    ifa.shift_up = 1'b0;
    ifa.all_wenable = 1'b0;
    check_eq("busy_ignore_matrix", ifa.all_rdata_list2d, model_flat());
    for (int i = 0; i < 3; i++) load_beat(rnd_row());
    check_eq("post_ignore_matrix", ifa.all_rdata_list2d, model_flat());

    // random idle-state operations
    for (int i = 0; i < 16; i++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          bulk = {$urandom, $urandom, $urandom};
          ifa.all_wenable = 1'b1;
          ifa.all_wdata_list2d = bulk;
          model_set_flat(bulk);
        end
        1: begin ifa.shift_up = 1'b1; model_shift_up(); end
        2: begin ifa.shift_left = 1'b1; model_shift_left(); end
        default: ifa.transpose = 1'b1;
      endcase
      tick();
      ifa.all_wenable = 1'b0; ifa.shift_up = 1'b0; ifa.shift_left = 1'b0; ifa.transpose = 1'b0;
      check_eq("rand_op_matrix", ifa.all_rdata_list2d, model_flat());
    end

    // asynchronous reset in the middle of a load
    load_beat(rnd_row());
    load_beat(rnd_row());
    #3;
    rstnn = 1'b0;
    #1;
    model_fill(0);
    lw = 0;
    check_eq("async_rst_matrix", ifa.all_rdata_list2d, model_flat());
    check_eq("async_rst_busy", 96'(ifa.busy), 96'(1'b0));
    check_eq("async_rst_rvalid", 96'(ifa.row_rvalid), 96'(1'b0));
    @(negedge clk);
    rstnn = 1'b1;
    tick();
    check_eq("wready_after_rst2", 96'(ifa.row_wready), 96'(1'b1));
    for (int i = 0; i < 4; i++) load_beat(rnd_row());
    check_eq("post_rst_load", ifa.all_rdata_list2d, model_flat());

    // 3x3 transpose: elements 1..9 row-major
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        b_flat[(r*3+c)*8 +: 8] = 8'(r*3 + c + 1);
        b_exp[(r*3+c)*8 +: 8]  = 8'(c*3 + r + 1);
      end
    ifb.all_wenable = 1'b1;
    ifb.all_wdata_list2d = b_flat;
    tick();
    ifb.all_wenable = 1'b0;
    check_eq("b_bulk", 96'(ifb.all_rdata_list2d), 96'(b_flat));
    ifb.transpose = 1'b1;
    tick();
    ifb.transpose = 1'b0;
    check_eq("b_transpose_row0", 96'(ifb.upmost_rdata_list1d), 96'(24'h070401));
    check_eq("b_transpose_all", 96'(ifb.all_rdata_list2d), 96'(b_exp));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dca_matrix_register_stream.md
Name: dca_matrix_register_stream

Overview:
- Parametrised successor to the square DCA matrix register.
- Holds a NUM_ROW x NUM_COL scalar matrix, which need not be square.
- Adds row-granular streaming load and drain ports with valid/ready handshakes, a load/drain state machine and a load-complete pulse.
- Keeps the bulk write, init, shift-up, shift-left and transpose operations; sits between DCA row-streaming engines and matrix compute lanes.

Parameters:
- NUM_ROW, 8: number of rows; must be >= 2.
- NUM_COL, 8: number of columns; must be >= 2.
- BW_TENSOR_SCALAR, 32: scalar width in bits.
- RESET_VALUE, 0: value of every element after reset.
- INIT_VALUE, RESET_VALUE: value of every element after init; also fills vacated elements on shift and drain.
- Derived localparams: BW_ROW = NUM_COL*BW_TENSOR_SCALAR; BW_MATRIX = NUM_ROW*BW_ROW; BW_ROWCNT = clog2(NUM_ROW+1); TRANSPOSE_EN = (NUM_ROW==NUM_COL).

Ports:
- clk  in  1  clock
- rstnn  in  1  reset; one clock; reset is asynchronous and active-low
- init  in  1  set all elements to INIT_VALUE; abort any stream
- all_wenable  in  1  bulk write of the whole matrix
- all_wdata_list2d  in  BW_MATRIX  bulk write data; row 0 in the LSBs, column 0 in the LSBs of each row
- shift_up  in  1  shift rows up; bottom row becomes INIT_VALUE
- shift_left  in  1  shift columns left; rightmost column becomes INIT_VALUE
- transpose  in  1  transpose; effective only when TRANSPOSE_EN
- row_wvalid  in  1  load beat valid
- row_wready  out  1  load beat ready
- row_wdata_list  in  BW_ROW  load row data
- load_done  out  1  one-cycle pulse after the last load beat
- drain_start  in  1  start draining NUM_ROW rows
- row_rvalid  out  1  drain beat valid
- row_rready  in  1  drain beat ready
- row_rdata_list  out  BW_ROW  drain row data, always equal to row 0
- busy  out  1  state is not IDLE
- all_rdata_list2d  out  BW_MATRIX  full matrix contents
- upmost_rdata_list1d  out  BW_ROW  row 0

Behaviour:
- Reset values: all elements = RESET_VALUE; state = IDLE; wcnt = rcnt = 0; load_done = 0; row_rvalid = 0; busy = 0. row_wready = 1 from the first clock edge after reset is released.
- States:
  - IDLE: row_wready=1, row_rvalid=0.
  - LOAD: row_wready=1, row_rvalid=0.
  - DRAIN: row_wready=0, row_rvalid=1.
- Load beat: a beat is accepted when row_wvalid && row_wready. The accepted row is written to row index wcnt and wcnt increments.
  - A beat accepted in IDLE moves the state to LOAD.
  - The beat with wcnt==NUM_ROW-1 clears wcnt, returns the state to IDLE and registers load_done=1 for the next cycle only.
  - Throughput is one row per cycle; wvalid gaps are allowed.
- Drain start: drain_start in IDLE, with no accepted load beat in the same cycle, moves the state to DRAIN. row_rvalid is asserted the following cycle.
- Drain beat: on row_rvalid && row_rready, rows shift up, the bottom row becomes INIT_VALUE and rcnt increments. The beat with rcnt==NUM_ROW-1 returns the state to IDLE with rcnt=0. No bubble between beats while rready stays high.
- Priority per cycle, highest first:
  1. init
  2. all_wenable
  3. stream beat (load or drain)
  4. transpose
  5. shift_up
  6. shift_left
- Only the highest asserted action takes effect.
- init in any state: all elements = INIT_VALUE, state = IDLE, counters = 0. load_done is not pulsed and a partial load is discarded.
- all_wenable, transpose, shift_up, shift_left and drain_start are ignored while busy=1.
- An all_wenable in IDLE together with a load beat: all_wenable wins, the beat is not accepted and row_wready is deasserted for that cycle.
- transpose with TRANSPOSE_EN=0 is a no-op.
- Matrix updates are registered: all_rdata_list2d reflects an operation in the cycle after it is applied.
- Asserting rstnn low mid-stream returns every register to its reset value immediately, without waiting for a clock edge.

Decomposition:
- Shared package/include (dca_matrix_stream_lpara.vb): BW_ROW, BW_MATRIX, BW_ROWCNT, and state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_DRAIN=2'd2.
- Sub-module dca_matrix_stream_ctrl: FSM, wcnt/rcnt, handshake outputs and load_done. It emits one-hot per-cycle operation selects.
- The top module holds the element array and the data-path muxes.

Test Plan:
(All scenarios use NUM_ROW=4, NUM_COL=3, BW_TENSOR_SCALAR=8, RESET_VALUE=0, INIT_VALUE=8'hFF.)
- Reset: pulse rstnn low mid-cycle -> all_rdata_list2d=0 asynchronously; busy=0, row_rvalid=0, load_done=0; row_wready=1 after the first clock edge.
- Streaming load: 4 beats with rows 0x030201, 0x060504, 0x090807, 0x0C0B0A and one idle cycle after beat 2 -> load_done pulses exactly once, one cycle after beat 4; upmost_rdata_list1d=0x030201; busy=0 afterwards.
- Drain with backpressure: after the load above, drain_start, then rready toggling 1,0,1,1,1 -> row_rdata_list sequence 0x030201, 0x060504, 0x090807, 0x0C0B0A; data held stable while rready=0; final matrix all 0xFF; busy falls after beat 4.
- Abort: init after 2 of 4 load beats -> matrix all 0xFF, state IDLE, no load_done; a new 4-beat load completes normally.
- Priority and ignore: all_wenable with a simultaneous wvalid in IDLE -> bulk data written, beat not accepted; shift_up while busy in LOAD -> no effect.
- Transpose gating: transpose with 4x3 -> unchanged. With NUM_ROW=NUM_COL=3 and elements 1..9 row-major -> row 0 reads 1,4,7.
